// File: rtl/alu_pkg.sv
// alu_pkg: shared datapath width and ALU opcode encodings
package alu_pkg;
  localparam int WIDTH = 64;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_LSL   = 4'b0100;
  localparam logic [3:0] ALU_LSR   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_ASR   = 4'b1000;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational opcode decode, result mux and zero detect
module alu_comb import alu_pkg::*; #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0] sh;
  assign sh = input_b[SW-1:0];
  always_comb begin
    case (alu_op)
      ALU_AND:   result = input_a & input_b;
      ALU_OR:    result = input_a | input_b;
      ALU_ADD:   result = input_a + input_b;
      ALU_XOR:   result = input_a ^ input_b;
      ALU_LSL:   result = input_a << sh;
      ALU_LSR:   result = input_a >> sh;
      ALU_SUB:   result = input_a - input_b;
      ALU_PASSB: result = input_b;
      ALU_ASR:   result = $signed(input_a) >>> sh;
      ALU_NOR:   result = ~(input_a | input_b);
      default:   result = '0;
    endcase
  end
  assign zero = ~|result;
endmodule

// File: rtl/alu_64.sv
// alu_64: registered ALU; result and Z describe the same operation one cycle later
module alu_64 import alu_pkg::*; #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [3:0]       ALUop,
  output logic [WIDTH-1:0] result,
  output logic             Z
);
  logic [WIDTH-1:0] result_d, result_q;
  logic z_d, z_q;
  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .input_a(input_a),
    .input_b(input_b),
    .alu_op (ALUop),
    .result (result_d),
    .zero   (z_d)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      z_q <= 1'b1;
    end else begin
      result_q <= result_d;
      z_q <= z_d;
    end
  end
  assign result = result_q;
  assign Z = z_q;
endmodule

// File: tb/tb_alu_64.sv
// tb_alu_64: table vectors, sweep and random stimulus against an arithmetic reference model
module tb_alu_64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] input_a = '0;
  logic [63:0] input_b = '0;
  logic [3:0] ALUop = '0;
  logic [63:0] result;
  logic Z;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  alu_64 dut (
    .clk    (clk),
    .reset  (reset),
    .input_a(input_a),
    .input_b(input_b),
    .ALUop  (ALUop),
    .result (result),
    .Z      (Z)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] p;
    p = 64'd1;
    repeat (int'(b[5:0])) p = p * 64'd2;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return a * p;
      4'd5:  return a / p;
      4'd6:  return a - b;
      4'd7:  return b;
      4'd8:  return a[63] ? ~((~a) / p) : a / p;
      4'd12: return ~(a | b);
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] er, input logic ez);
    n_checks++;
    if (result !== er || Z !== ez) begin
      n_fail++;
      $display("FAIL %s: got result=%h Z=%b, want result=%h Z=%b", name, result, Z, er, ez);
    end
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] e;
    e = model(op, a, b);
    ALUop = op;
    input_a = a;
    input_b = b;
    @(posedge clk);
    #1;
    chk(name, e, e == 64'd0);
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{4'b0001, 64'h0F, 64'h30, 64'h3F};
    tbl[1]  = '{4'b0010, 64'h10, 64'h0F, 64'h1F};
    tbl[2]  = '{4'b0011, 64'h0F, 64'h0F, 64'h0};
    tbl[3]  = '{4'b0110, 64'h3, 64'h3, 64'h0};
    tbl[4]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0};
    tbl[5]  = '{4'b0110, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[6]  = '{4'b0100, 64'h1, 64'd63, 64'h8000_0000_0000_0000};
    tbl[7]  = '{4'b0101, 64'h8000_0000_0000_0000, 64'd63, 64'h1};
    tbl[8]  = '{4'b1000, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};
    tbl[9]  = '{4'b0100, 64'h1234_5678, 64'h40, 64'h1234_5678};
    tbl[10] = '{4'b0000, 64'hF0F0, 64'h0FF0, 64'h00F0};
    tbl[11] = '{4'b1100, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[12] = '{4'b0111, 64'h5, 64'h0, 64'h0};
    tbl[13] = '{4'b1111, 64'h5, 64'h7, 64'h0};
    tbl[14] = '{4'b1000, 64'h4000_0000_0000_0001, 64'hFFC1, 64'h2000_0000_0000_0000};
    tbl[15] = '{4'b0101, 64'hFFFF_0000_0000_0000, 64'h10, 64'h0000_FFFF_0000_0000};

    ALUop = 4'b0010;
    input_a = 64'd5;
    input_b = 64'd7;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset", 64'd0, 1'b1);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_add", 64'h0C, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ALUop = tbl[i].op;
      input_a = tbl[i].a;
      input_b = tbl[i].b;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), tbl[i].exp, tbl[i].exp == 64'd0);
    end

    run("b2b_add", 4'b0010, 64'd100, 64'd23);
    run("b2b_sub", 4'b0110, 64'd50, 64'd50);
    run("b2b_and", 4'b0000, 64'hFF00, 64'h0FF0);

    for (int op = 1; op <= 6; op++)
      for (int a = 0; a < 256; a++)
        for (int b = 0; b < 16; b++)
          run("sweep", 4'(op), 64'(a), 64'(b));

    for (int i = 0; i < 3000; i++)
      run("random", 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});

    ALUop = 4'b0010;
    input_a = 64'd1;
    input_b = 64'd1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_midrun", 64'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
